// File: rtl/aes_byte_link.sv
// Byte-serial front end for an AES cipher core: gathers a 16-byte key and
// plaintext, restarts the core, waits out its latency and streams the result.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | reset state, leaves for LOAD_KEY on the first edge
// LOAD_KEY  | accepting key bytes 0..15 into core_key
// LOAD_TEXT | accepting plaintext bytes 0..15 into core_text
// START     | one-cycle core_reset pulse, wait counter cleared
// WAIT      | counting core latency, captures core_result at Nr+1
// SEND      | streaming result bytes 0..15 with valid/ready handshake
module aes_byte_link #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         key_hold,
   output logic         core_reset,
   output logic [0:127] core_key,
   output logic [0:127] core_text,
   input  logic [0:127] core_result,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy
);

   // Wide enough for Nr+1 at the largest key size (Nk=8 -> 15).
   localparam int WAIT_W = $clog2(Nr + 2);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(Nr + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_TEXT,
      START,
      WAIT,
      SEND
   } state_t;

   state_t              state;
   logic [3:0]          idx;
   logic [3:0]          odx;
   logic [3:0]          odx_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [WAIT_W-1:0]   wait_nxt;
   logic [0:127]        result_q;
   logic                in_take;
   logic                out_take;

   always_comb begin
      in_take  = in_valid && in_ready;
      out_take = out_valid && out_ready;
      odx_nxt  = odx + 4'd1;
      wait_nxt = wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         odx        <= '0;
         wait_cnt   <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         core_reset <= 1'b0;
         busy       <= 1'b0;
         core_key   <= '0;
         core_text  <= '0;
         result_q   <= '0;
      end else begin
         core_reset <= 1'b0;
         case (state)
            IDLE: begin
               state    <= LOAD_KEY;
               idx      <= '0;
               in_ready <= 1'b1;
            end
            LOAD_KEY: begin
               if (in_take) begin
                  core_key[{idx, 3'b000} +: 8] <= in_data;
                  idx <= idx + 4'd1;
                  if (idx == 4'd15) begin
                     state <= LOAD_TEXT;
                  end
               end
            end
            LOAD_TEXT: begin
               if (in_take) begin
                  core_text[{idx, 3'b000} +: 8] <= in_data;
                  idx <= idx + 4'd1;
                  if (idx == 4'd15) begin
                     state      <= START;
                     in_ready   <= 1'b0;
                     busy       <= 1'b1;
                     core_reset <= 1'b1;
                  end
               end
            end
            START: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               wait_cnt <= wait_nxt;
               if (wait_nxt == WAIT_LAST) begin
                  state     <= SEND;
                  result_q  <= core_result;
                  odx       <= '0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  out_data  <= core_result[0 +: 8];
               end
            end
            SEND: begin
               if (out_take) begin
                  if (odx == 4'd15) begin
                     // key_hold only matters on the final handshake
                     state     <= key_hold ? LOAD_TEXT : LOAD_KEY;
                     odx       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     odx      <= odx_nxt;
                     out_data <= result_q[{odx_nxt, 3'b000} +: 8];
                     out_last <= (odx_nxt == 4'd15);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_byte_link.sv
// Bench for aes_byte_link: behavioural AES-128 core model, randomized byte
// traffic, and a queue-based scoreboard checked by an independent monitor.
module tb_aes_byte_link;
   localparam int NK = 4;
   localparam int NR = NK + 6;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         key_hold = 1'b0;
   logic         core_reset;
   logic [127:0] core_key;
   logic [127:0] core_text;
   logic [127:0] core_result;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_last;
   logic         busy;

   int checks = 0;
   int passes = 0;

   aes_byte_link #(.Nk(NK)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .key_hold(key_hold), .core_reset(core_reset),
      .core_key(core_key), .core_text(core_text), .core_result(core_result),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- AES-128 reference ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv = 8'h00;
         for (int u = 1; u < 256; u++)
            if (v != 0 && gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
         sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] rk [176];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] rc, t0, a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         s[i]  = pt[127-8*i -: 8] ^ rk[i];
      end
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
         if (i % 16 == 0) begin
            t0 = tmp[0];
            tmp[0] = sbox[tmp[1]] ^ rc;
            tmp[1] = sbox[tmp[2]];
            tmp[2] = sbox[tmp[3]];
            tmp[3] = sbox[t0];
            rc = xt(rc);
         end
         for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) t[c*4+rw] = s[((c+rw)%4)*4+rw];
         for (int c = 0; c < 4; c++) begin
            a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
            if (rnd < 10) begin
               s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[c*4] = a0; s[c*4+1] = a1; s[c*4+2] = a2; s[c*4+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*rnd+i];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // Core model: result valid NR edges after it samples core_reset, stub pattern before.
   logic [7:0]   since = 8'hff;
   logic [127:0] core_res_q = '0;
   always @(posedge clk) begin
      if (core_reset) begin
         since      <= 8'h00;
         core_res_q <= aes128(core_key, core_text);
      end else if (since != 8'hff) begin
         since <= since + 8'h01;
      end
   end
   assign core_result = (since >= 8'(NR)) ? core_res_q : 128'hdead_beef_5a5a_a5a5_0f0f_f0f0_1234_5678;

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;
   exp_t sb [$];

   task automatic push_result(input logic [127:0] r);
      for (int i = 0; i < 16; i++) sb.push_back({r[127-8*i -: 8], (i == 15)});
   endtask

   logic       mon_stalled = 1'b0;
   logic [7:0] mon_held = '0;
   exp_t       mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (reset && out_valid) begin
            if (mon_stalled) chk("stall_hold", 128'(out_data), 128'(mon_held));
            if (out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_byte: got %0h, expected none", out_data);
               end else begin
                  mon_e = sb.pop_front();
                  chk("out_data", 128'(out_data), 128'(mon_e.d));
                  chk("out_last", 128'(out_last), 128'(mon_e.l));
               end
               mon_stalled = 1'b0;
            end else begin
               mon_stalled = 1'b1;
               mon_held    = out_data;
            end
         end else begin
            mon_stalled = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   // All tasks start and end at posedge+1.
   task automatic load_bytes(input logic [127:0] v, input int n, input bit gaps);
      int i = 0;
      int cyc = 0;
      bit acc;
      while (i < n && cyc < 400) begin
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = in_valid ? v[127-8*i -: 8] : 8'($urandom);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) i++;
      end
      in_valid = 1'b0;
      if (i < n) begin
         checks++;
         $display("FAIL load_timeout: accepted %0d bytes, expected %0d", i, n);
      end
   endtask

   task automatic drain(input logic [127:0] key, input logic [127:0] text, input bit kh,
                        input bit stall, input bit hold_valid, input int abort_at,
                        output bit aborted);
      int n = 0;
      int stall_cnt = 0;
      int cyc = 0;
      int pulses = 0;
      int t_rst = -1;
      int t_valid = -1;
      aborted = 1'b0;
      while (n < 16 && cyc < 200) begin
         if (abort_at >= 0 && n == abort_at && out_valid) begin
            aborted = 1'b1;
            break;
         end
         out_ready = !(stall && n == 7 && out_valid && stall_cnt < 3);
         if (!out_ready) stall_cnt++;
         key_hold = out_last ? kh : ~kh;
         in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         @(negedge clk);
         chk("busy_in_ready", 128'({busy, in_ready}), 128'(2'b10));
         chk("core_key_hold", core_key, key);
         chk("core_text_hold", core_text, text);
         if (core_reset) begin
            pulses++;
            if (t_rst < 0) t_rst = cyc;
         end
         if (out_valid && t_valid < 0) t_valid = cyc;
         if (out_valid && out_ready) n++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!aborted) begin
         if (n < 16) begin
            checks++;
            $display("FAIL drain_timeout: got %0d bytes, expected 16", n);
         end
         chk("core_reset_pulses", 128'(pulses), 128'(1));
         // Capture edge is NR+1 edges after the edge that ends the pulse.
         chk("capture_latency", 128'(t_valid - t_rst), 128'(NR + 2));
      end
   endtask

   task automatic reset_and_check();
      reset = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_ctrl", 128'({in_ready, out_valid, out_last, core_reset, busy, out_data}), 128'(0));
      chk("rst_core_key", core_key, 128'(0));
      chk("rst_core_text", core_text, 128'(0));
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("idle_after_release", 128'({in_ready, busy}), 128'(0));
      @(posedge clk); #1;
      chk("load_key_entry", 128'(in_ready), 128'(1));
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [127:0] key, text;
   bit kh, need_key, ab;

   initial begin
      build_sbox();
      @(posedge clk); #1;
      reset_and_check();

      // Known-answer block, stall on byte 7, keep the key.
      key  = 128'h000102030405060708090a0b0c0d0e0f;
      text = 128'h00112233445566778899aabbccddeeff;
      load_bytes(key, 16, 1'b1);
      load_bytes(text, 16, 1'b1);
      push_result(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      drain(key, text, 1'b1, 1'b1, 1'b0, -1, ab);

      // Text only with the held key; in_valid held high during WAIT/SEND.
      text = rnd128();
      load_bytes(text, 16, 1'b1);
      push_result(aes128(key, text));
      drain(key, text, 1'b0, 1'b0, 1'b1, -1, ab);
      need_key = 1'b1;

      for (int b = 0; b < 6; b++) begin
         if (need_key) key = rnd128();
         text = rnd128();
         kh   = 1'($urandom_range(0, 1));
         if (need_key) load_bytes(key, 16, 1'b1);
         load_bytes(text, 16, (b % 2) == 0);
         push_result(aes128(key, text));
         drain(key, text, kh, (b % 2) == 1, (b % 3) == 0, -1, ab);
         need_key = !kh;
      end

      // Reset after 9 text bytes.
      if (need_key) begin
         key = rnd128();
         load_bytes(key, 16, 1'b1);
      end
      load_bytes(rnd128(), 9, 1'b1);
      reset_and_check();

      key  = rnd128();
      text = rnd128();
      load_bytes(key, 16, 1'b1);
      load_bytes(text, 16, 1'b1);
      push_result(aes128(key, text));
      drain(key, text, 1'b0, 1'b1, 1'b0, -1, ab);

      // Reset while byte 4 of the result is on the output.
      key  = rnd128();
      text = rnd128();
      load_bytes(key, 16, 1'b1);
      load_bytes(text, 16, 1'b1);
      push_result(aes128(key, text));
      drain(key, text, 1'b0, 1'b0, 1'b0, 4, ab);
      chk("abort_reached", 128'(ab), 128'(1));
      reset_and_check();
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("no_output_after_reset", 128'(out_valid), 128'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b0;

      key  = rnd128();
      text = rnd128();
      load_bytes(key, 16, 1'b1);
      load_bytes(text, 16, 1'b0);
      push_result(aes128(key, text));
      drain(key, text, 1'b0, 1'b1, 1'b1, -1, ab);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/aes_byte_link.md
AES_BYTE_LINK -- requirements
Module: aes_byte_link

Interface
REQ-001 SHALL have parameter Nk, default 4, meaning key length in 32-bit words.
REQ-002 SHALL have parameter Nr, default Nk+6, meaning cipher round count; core latency is Nr+1 cycles.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8  key or plaintext byte.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid byte.
REQ-007 SHALL have port in_ready  output  1  the block accepts a byte this cycle.
REQ-008 SHALL have port key_hold  input  1  reuse the loaded key for the next block.
REQ-009 SHALL have port core_reset  output  1  active-high restart pulse to the cipher core.
REQ-010 SHALL have port core_key  output  128  assembled key, bits [0:127], byte 0 in bits [0:7].
REQ-011 SHALL have port core_text  output  128  assembled plaintext, same byte order as core_key.
REQ-012 SHALL have port core_result  input  128  cipher core output state.
REQ-013 SHALL have port out_data  output  8  result byte.
REQ-014 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-015 SHALL have port out_ready  input  1  the consumer accepts the byte.
REQ-016 SHALL have port out_last  output  1  out_data is result byte 15.
REQ-017 SHALL have port busy  output  1  high in every state other than IDLE, LOAD_KEY and LOAD_TEXT.

Function
REQ-018 SHALL implement the states IDLE, LOAD_KEY, LOAD_TEXT, START, WAIT and SEND, with IDLE as the reset state.
REQ-019 SHALL move IDLE -> LOAD_KEY unconditionally on the first edge after reset deasserts.
REQ-020 SHALL register in_ready, driving it high only in LOAD_KEY and LOAD_TEXT.
REQ-021 SHALL accept a byte only when in_valid & in_ready, write it to byte slot idx (bits [8*idx:8*idx+7]), and increment 4-bit idx.
REQ-022 SHALL leave idx and the target register unchanged on a cycle with in_valid low (no wrap or skip).
REQ-023 SHALL, on the 16th accepted key byte, clear idx and enter LOAD_TEXT.
REQ-024 SHALL, on the 16th accepted text byte, clear idx, deassert in_ready on the next edge and enter START.
REQ-025 SHALL, in START, assert core_reset for exactly one cycle, clear the wait counter and enter WAIT.
REQ-026 SHALL hold core_key and core_text stable from START until SEND exits.
REQ-027 SHALL, in WAIT, increment the wait counter every cycle and, when it reaches Nr+1, capture core_result into the 128-bit output register and enter SEND.
REQ-028 SHALL size the wait counter to hold Nr+1 for any legal Nk (4, 6 or 8).
REQ-029 SHALL, in SEND, drive out_valid=1 and out_data = output byte odx (starting at byte 0), and assert out_last when odx=15.
REQ-030 SHALL hold out_data stable while out_valid & !out_ready, advancing odx only on out_valid & out_ready.
REQ-031 SHALL, on the byte-15 handshake, drop out_valid on the next edge and enter LOAD_TEXT if key_hold=1 (key retained) or LOAD_KEY if key_hold=0.
REQ-032 SHALL sample key_hold only on the byte-15 handshake cycle.
REQ-033 SHALL ignore in_valid in START, WAIT and SEND, neither consuming nor buffering bytes.

Reset
REQ-034 SHALL, while reset=0, asynchronously force state=IDLE, idx=odx=0, wait counter=0, in_ready=0, out_valid=0, out_last=0, out_data=0, core_reset=0, busy=0, and core_key, core_text and the output register to 0.
REQ-035 SHALL, on reset assertion in any state (including mid-load or mid-SEND), discard partial data, resume at IDLE and emit no remaining bytes.

Verification
REQ-036 Bench SHALL load key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff with a real Cipher (Nk=4) -> core_reset pulses once, out stream 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, out_last only on 5a.
REQ-037 Bench SHALL use a stub core returning a fixed pattern and count cycles -> capture exactly 11 cycles after the core_reset pulse; busy high throughout START, WAIT and SEND.
REQ-038 Bench SHALL toggle in_valid randomly during load and hold out_ready low for 3 cycles on byte 7 -> byte order intact; out_data stable while stalled; no duplicate or lost bytes.
REQ-039 Bench SHALL send key_hold=1 at byte 15, then 16 new text bytes -> no key bytes requested; core_key unchanged; second result correct.
REQ-040 Bench SHALL assert reset after 9 text bytes and again during SEND byte 4 -> all outputs at REQ-034 values immediately; IDLE->LOAD_KEY after release; the next full load completes correctly.
REQ-041 Bench SHALL drive in_valid=1 continuously through WAIT and SEND -> in_ready stays 0 and no byte is consumed until LOAD_KEY or LOAD_TEXT.
